// File: rtl/regs_file_clr.sv
// Parametrised register file with %0 tied to zero, two combinational read ports,
// one write port and a sequential clear engine. Define REGS_BYPASS_EN for write-through reads.
//
// state | meaning
// IDLE  | normal operation; writes accepted, clr sampled
// CLEAR | sweep clearing gpr[cnt] each cycle; writes blocked, busy high
module regs_file_clr #(
  parameter int n     = 8,
  parameter int NREGS = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          w,
  input  logic [AW-1:0] Waddr,
  input  logic [n-1:0]  Wdata,
  input  logic [AW-1:0] Raddr1,
  input  logic [AW-1:0] Raddr2,
  output logic [n-1:0]  Rdata1,
  output logic [n-1:0]  Rdata2,
  input  logic          clr,
  output logic          busy,
  output logic          done
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [AW:0]   LIMIT = (AW+1)'(NREGS);
  localparam logic [AW-1:0] LAST  = AW'(NREGS - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic          done_q, done_nxt;
  logic          wr_en;
  logic [n-1:0]  gpr [NREGS];

  assign wr_en = w && (state == IDLE) && (Waddr != '0) && ({1'b0, Waddr} < LIMIT);
  assign busy  = (state == CLEAR);
  assign done  = done_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state  <= IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      done_q <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (clr) begin
          state_nxt = CLEAR;
          cnt_nxt   = AW'(1);
        end
      end
      CLEAR: begin
        cnt_nxt = cnt + AW'(1);
        if (cnt == LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Entry 0 is only ever reset; reads of %0 are forced to zero below anyway.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < NREGS; i++) gpr[i] <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (state == CLEAR && cnt == AW'(i))
          gpr[i] <= '0;
        else if (wr_en && Waddr == AW'(i))
          gpr[i] <= Wdata;
      end
    end
  end

  always_comb begin
    Rdata1 = '0;
    if (Raddr1 != '0 && {1'b0, Raddr1} < LIMIT) Rdata1 = gpr[Raddr1];
`ifdef REGS_BYPASS_EN
    if (wr_en && Waddr == Raddr1) Rdata1 = Wdata;
`endif
  end

  always_comb begin
    Rdata2 = '0;
    if (Raddr2 != '0 && {1'b0, Raddr2} < LIMIT) Rdata2 = gpr[Raddr2];
`ifdef REGS_BYPASS_EN
    if (wr_en && Waddr == Raddr2) Rdata2 = Wdata;
`endif
  end

endmodule

// File: tb/tb_regs_file_clr.sv
// Scoreboard bench for regs_file_clr: default 16-entry instance plus a 12-entry
// instance for out-of-range addressing.
module tb_regs_file_clr;

  logic       clk = 1'b0;
  logic       nreset;
  logic       w, clr;
  logic [3:0] Waddr, Raddr1, Raddr2;
  logic [7:0] Wdata, Rdata1, Rdata2;
  logic       busy, done;

  logic       s_w, s_clr;
  logic [3:0] s_waddr, s_raddr1, s_raddr2;
  logic [7:0] s_wdata, s_rdata1, s_rdata2;
  logic       s_busy, s_done;

  int checks = 0;
  int failures = 0;

  logic [7:0] gm [16];
  logic [7:0] exp_q [$];
  logic [1:0] ctl_q [$];
  logic [7:0] e1, e2;
  logic [1:0] ec;

  always #5 clk = ~clk;

  regs_file_clr dut (
    .clk(clk), .nreset(nreset), .w(w), .Waddr(Waddr), .Wdata(Wdata),
    .Raddr1(Raddr1), .Raddr2(Raddr2), .Rdata1(Rdata1), .Rdata2(Rdata2),
    .clr(clr), .busy(busy), .done(done)
  );

  regs_file_clr #(.n(8), .NREGS(12), .AW(4)) u_small (
    .clk(clk), .nreset(nreset), .w(s_w), .Waddr(s_waddr), .Wdata(s_wdata),
    .Raddr1(s_raddr1), .Raddr2(s_raddr2), .Rdata1(s_rdata1), .Rdata2(s_rdata2),
    .clr(s_clr), .busy(s_busy), .done(s_done)
  );

  function automatic logic [7:0] model_rd(input logic [3:0] a);
    return (a == 4'd0) ? 8'h00 : gm[a];
  endfunction

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    w = 1'b1; Waddr = a; Wdata = d;
    @(negedge clk);
    w = 1'b0;
    if (a != 4'd0) gm[a] = d;
  endtask

  task automatic test_reset;
    nreset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL reset_ctl: busy/done=%b expected 00", {busy, done});
    end
    nreset = 1'b1;
    for (int a = 0; a < 16; a++) gm[a] = 8'h00;
    for (int a = 0; a < 16; a++) begin
      Raddr1 = 4'(a); Raddr2 = 4'(15 - a);
      exp_q.push_back(model_rd(Raddr1));
      exp_q.push_back(model_rd(Raddr2));
      #1;
      e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
      checks++;
      if (Rdata1 !== e1 || Rdata2 !== e2) begin
        failures++;
        $display("FAIL reset_read a=%0d: got %h/%h expected %h/%h", a, Rdata1, Rdata2, e1, e2);
      end
    end
  endtask

  task automatic test_write_read;
    do_write(4'd3, 8'hA5);
    Raddr1 = 4'd3; Raddr2 = 4'd0;
    exp_q.push_back(8'hA5); exp_q.push_back(8'h00);
    #1;
    e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
    checks++;
    if (Rdata1 !== e1 || Rdata2 !== e2) begin
      failures++;
      $display("FAIL write_read: got %h/%h expected %h/%h", Rdata1, Rdata2, e1, e2);
    end
    do_write(4'd0, 8'hFF);
    Raddr1 = 4'd0; Raddr2 = 4'd3;
    exp_q.push_back(8'h00); exp_q.push_back(model_rd(4'd3));
    #1;
    e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
    checks++;
    if (Rdata1 !== e1 || Rdata2 !== e2) begin
      failures++;
      $display("FAIL zero_reg: got %h/%h expected %h/%h", Rdata1, Rdata2, e1, e2);
    end
  endtask

  task automatic test_bypass;
    @(negedge clk);
    w = 1'b1; Waddr = 4'd5; Wdata = 8'h3C; Raddr1 = 4'd5; Raddr2 = 4'd5;
`ifdef REGS_BYPASS_EN
    exp_q.push_back(8'h3C);
`else
    exp_q.push_back(gm[5]);
`endif
    #1;
    e1 = exp_q.pop_front();
    checks++;
    if (Rdata1 !== e1 || Rdata2 !== e1) begin
      failures++;
      $display("FAIL same_cycle_read: got %h/%h expected %h", Rdata1, Rdata2, e1);
    end
    @(negedge clk);
    w = 1'b0;
    gm[5] = 8'h3C;
    exp_q.push_back(8'h3C);
    #1;
    e1 = exp_q.pop_front();
    checks++;
    if (Rdata1 !== e1) begin
      failures++;
      $display("FAIL next_cycle_read: got %h expected %h", Rdata1, e1);
    end
  endtask

  task automatic test_clear;
    for (int i = 1; i < 16; i++) do_write(4'(i), 8'(8'h10 + i));
    @(negedge clk);
    clr = 1'b1; w = 1'b1; Waddr = 4'd9; Wdata = 8'h5A;
    gm[9] = 8'h5A;
    @(negedge clk);
    clr = 1'b0; w = 1'b0;
    #1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      ctl_q.push_back({cyc < 15, cyc == 15});
      ec = ctl_q.pop_front();
      checks++;
      if ({busy, done} !== ec) begin
        failures++;
        $display("FAIL sweep_ctl cyc=%0d: busy/done=%b expected %b", cyc, {busy, done}, ec);
      end
      if (cyc == 3) begin
        Raddr1 = 4'd3; Raddr2 = 4'd4;
        w = 1'b1; Waddr = 4'd2; Wdata = 8'h77;
        exp_q.push_back(8'h00); exp_q.push_back(gm[4]);
        #1;
        e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
        checks++;
        if (Rdata1 !== e1 || Rdata2 !== e2) begin
          failures++;
          $display("FAIL mid_sweep_read: got %h/%h expected %h/%h", Rdata1, Rdata2, e1, e2);
        end
      end
      if (cyc == 4) w = 1'b0;
      if (cyc == 6) clr = 1'b1;
      if (cyc == 7) clr = 1'b0;
      @(negedge clk);
      #1;
    end
    for (int a = 0; a < 16; a++) gm[a] = 8'h00;
    for (int a = 0; a < 16; a++) begin
      Raddr1 = 4'(a); Raddr2 = 4'(a);
      exp_q.push_back(model_rd(4'(a)));
      #1;
      e1 = exp_q.pop_front();
      checks++;
      if (Rdata1 !== e1 || Rdata2 !== e1) begin
        failures++;
        $display("FAIL post_clear a=%0d: got %h/%h expected %h", a, Rdata1, Rdata2, e1);
      end
    end
  endtask

  task automatic test_midsweep_reset;
    int done_seen;
    done_seen = 0;
    for (int i = 1; i < 16; i++) do_write(4'(i), 8'(8'hC0 + i));
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      ctl_q.push_back(2'b10);
      ec = ctl_q.pop_front();
      checks++;
      if ({busy, done} !== ec) begin
        failures++;
        $display("FAIL pre_reset_ctl cyc=%0d: busy/done=%b expected %b", cyc, {busy, done}, ec);
      end
      if (cyc < 4) begin
        @(negedge clk);
        #1;
      end
    end
    nreset = 1'b0;
    #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL reset_mid_sweep_ctl: busy/done=%b expected 00", {busy, done});
    end
    for (int a = 0; a < 16; a++) gm[a] = 8'h00;
    for (int a = 0; a < 16; a++) begin
      Raddr1 = 4'(a); Raddr2 = 4'(15 - a);
      exp_q.push_back(model_rd(Raddr1));
      #1;
      e1 = exp_q.pop_front();
      checks++;
      if (Rdata1 !== e1 || Rdata2 !== e1) begin
        failures++;
        $display("FAIL reset_mid_sweep_read a=%0d: got %h/%h expected %h", a, Rdata1, Rdata2, e1);
      end
    end
    @(negedge clk);
    nreset = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      failures++;
      $display("FAIL no_done_after_reset: active cycles=%0d expected 0", done_seen);
    end
  endtask

  task automatic test_out_of_range;
    logic [3:0] wa [3];
    logic [7:0] exp_small [3];
    wa[0] = 4'd11; wa[1] = 4'd12; wa[2] = 4'd13;
    exp_small[0] = 8'h22; exp_small[1] = 8'h00; exp_small[2] = 8'h00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      s_w = 1'b1; s_waddr = wa[k]; s_wdata = (k == 0) ? 8'h22 : 8'h11;
      @(negedge clk);
      s_w = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      s_raddr1 = wa[k]; s_raddr2 = wa[k];
      exp_q.push_back(exp_small[k]);
      #1;
      e1 = exp_q.pop_front();
      checks++;
      if (s_rdata1 !== e1 || s_rdata2 !== e1) begin
        failures++;
        $display("FAIL out_of_range a=%0d: got %h/%h expected %h", wa[k], s_rdata1, s_rdata2, e1);
      end
    end
  endtask

  initial begin
    nreset = 1'b0; w = 1'b0; clr = 1'b0;
    Waddr = '0; Wdata = '0; Raddr1 = '0; Raddr2 = '0;
    s_w = 1'b0; s_clr = 1'b0; s_waddr = '0; s_wdata = '0; s_raddr1 = '0; s_raddr2 = '0;
    test_reset();
    test_write_read();
    test_bypass();
    test_clear();
    test_midsweep_reset();
    test_out_of_range();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
